// File: rtl/gpu_cmd_pkg.sv
// gpu_cmd_pkg: shared FSM states, error codes, sync marker and command opcodes
package gpu_cmd_pkg;
  typedef enum logic [2:0] {S_IDLE, S_OPCODE, S_LEN, S_PAYLOAD, S_CSUM} state_t;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_LEN     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] OP_SWAP              = 8'h01;
  localparam logic [7:0] OP_CLEAN             = 8'h02;
  localparam logic [7:0] OP_LOAD_VERTEX_BEGIN = 8'h03;
  localparam logic [7:0] OP_LOAD_VERTEX_CONT  = 8'h04;
  localparam logic [7:0] OP_LOAD_EDGE_BEGIN   = 8'h05;
  localparam logic [7:0] OP_LOAD_EDGE_CONT    = 8'h06;
  localparam logic [7:0] OP_STATUS            = 8'h07;
endpackage

// File: rtl/pkt_timeout_timer.sv
// pkt_timeout_timer: inter-byte idle counter
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the count (byte seen, idle, or expiry)
//   en         : count this cycle
//   expire     : counting and the count has reached TIMEOUT_CYCLES-1
module pkt_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
  assign expire = en && cnt == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/cmd_packet_assembler.sv
// cmd_packet_assembler: frames SYNC/OPCODE/LEN/payload/CSUM packets from a byte stream
//   CLK, rst_n     : clock, async active-low reset
//   rx_valid/data  : one-cycle byte strobe, no backpressure
//   opcode, payload, payload_len : last good packet (payload byte k at [8k+7:8k])
//   packet_ready   : one-cycle pulse on a new good packet
//   err, err_code  : one-cycle abort pulse; code 01 csum, 10 length, 11 timeout
//   busy           : inside a packet
module cmd_packet_assembler
  import gpu_cmd_pkg::*;
#(
  parameter int         MAX_PAYLOAD    = 8,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic [7:0]               opcode,
  output logic [8*MAX_PAYLOAD-1:0] payload,
  output logic [7:0]               payload_len,
  output logic                     packet_ready,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic                     busy
);
  state_t state, nxt;
  logic [7:0] wop, wlen, idx, csum;
  logic [8*MAX_PAYLOAD-1:0] wpay;
  logic ok, bad, expire, tmo;
  logic [1:0] code;
  assign busy = state != S_IDLE;
  assign tmo = busy && !rx_valid && expire;
  pkt_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(CLK), .rst_n(rst_n),
    .clr(rx_valid || !busy || tmo),
    .en(!rx_valid && busy),
    .expire(expire)
  );
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    ok = 1'b0;
    bad = 1'b0;
    code = err_code;
    if (tmo) begin
      nxt = S_IDLE;
      bad = 1'b1;
      code = ERR_TIMEOUT;
    end else if (rx_valid) begin
      case (state)
        S_IDLE:    nxt = rx_data == SYNC_BYTE ? S_OPCODE : S_IDLE;
        S_OPCODE:  nxt = S_LEN;
        S_LEN: begin
          bad = rx_data > 8'(MAX_PAYLOAD);
          code = bad ? ERR_LEN : err_code;
          nxt = bad ? S_IDLE : rx_data == 8'd0 ? S_CSUM : S_PAYLOAD;
        end
        S_PAYLOAD: nxt = idx == wlen - 8'd1 ? S_CSUM : S_PAYLOAD;
        S_CSUM: begin
          ok = rx_data == csum;
          bad = !ok;
          code = ok ? err_code : ERR_CSUM;
          nxt = S_IDLE;
        end
        default:   nxt = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      wop <= '0;
      wlen <= '0;
      idx <= '0;
      csum <= '0;
      wpay <= '0;
      opcode <= '0;
      payload <= '0;
      payload_len <= '0;
      packet_ready <= 1'b0;
      err <= 1'b0;
      err_code <= '0;
    end else begin
      packet_ready <= ok;
      err <= bad;
      err_code <= code;
      if (ok) begin
        opcode <= wop;
        payload <= wpay;
        payload_len <= wlen;
      end
      if (rx_valid && !tmo)
        case (state)
          S_OPCODE: begin
            wop <= rx_data;
            csum <= rx_data;
          end
          S_LEN: begin
            csum <= csum ^ rx_data;
            wlen <= rx_data;
            idx <= '0;
            // cleared even for LEN=0 so unused bytes of a zero-length packet read as 0
            wpay <= '0;
          end
          S_PAYLOAD: begin
            csum <= csum ^ rx_data;
            idx <= idx + 8'd1;
            for (int k = 0; k < MAX_PAYLOAD; k++)
              if (idx == 8'(k)) wpay[8*k +: 8] <= rx_data;
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_cmd_packet_assembler.sv
module tb_cmd_packet_assembler;
  localparam int MAXP = 8;
  localparam int TO = 16;
  logic CLK = 0, rst_n = 0, rx_valid = 0;
  logic [7:0] rx_data = 0;
  logic [7:0] opcode, payload_len;
  logic [8*MAXP-1:0] payload;
  logic packet_ready, err, busy;
  logic [1:0] err_code;
  int total = 0, bad = 0, rdy_cnt = 0;

  cmd_packet_assembler #(.MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TO), .SYNC_BYTE(8'hA5)) dut (
    .CLK(CLK), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .opcode(opcode), .payload(payload), .payload_len(payload_len),
    .packet_ready(packet_ready), .err(err), .err_code(err_code), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask

  // Model: collect the bytes of the current packet in a queue and judge it
  // once it is complete, with a plain idle-cycle count for the timeout.
  logic [7:0] q[$];
  int idle;
  logic [7:0] e_op, e_len;
  logic [63:0] e_pay;
  logic e_rdy, e_err, e_busy;
  logic [1:0] e_code;
  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); idle = 0;
      e_op = 0; e_len = 0; e_pay = 0; e_rdy = 0; e_err = 0; e_code = 0; e_busy = 0;
    end else begin
      e_rdy = 0; e_err = 0;
      if (rx_valid) begin
        idle = 0;
        if (q.size() == 0) begin
          if (rx_data == 8'hA5) q.push_back(rx_data);
        end else begin
          q.push_back(rx_data);
          if (q.size() == 3 && q[2] > MAXP) begin
            e_err = 1; e_code = 2'b10; q.delete();
          end else if (q.size() >= 3 && q.size() == int'(q[2]) + 4) begin
            logic [7:0] x;
            x = 0;
            for (int i = 1; i < q.size() - 1; i++) x ^= q[i];
            if (x == q[q.size()-1]) begin
              e_rdy = 1; e_op = q[1]; e_len = q[2]; e_pay = 0;
              for (int i = 0; i < int'(q[2]); i++) e_pay[8*i +: 8] = q[3+i];
            end else begin
              e_err = 1; e_code = 2'b01;
            end
            q.delete();
          end
        end
      end else if (q.size() > 0) begin
        idle++;
        if (idle == TO) begin
          e_err = 1; e_code = 2'b11; q.delete(); idle = 0;
        end
      end
      e_busy = q.size() > 0;
    end
  end

  always @(negedge CLK) begin
    chk("opcode", 64'(opcode), 64'(e_op));
    chk("payload", payload, e_pay);
    chk("payload_len", 64'(payload_len), 64'(e_len));
    chk("packet_ready", 64'(packet_ready), 64'(e_rdy));
    chk("err", 64'(err), 64'(e_err));
    chk("err_code", 64'(err_code), 64'(e_code));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("ready_err_excl", 64'(packet_ready && err), 64'd0);
    if (packet_ready) rdy_cnt++;
  end

  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    rx_valid = 1; rx_data = b;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge CLK);
      rx_valid = 0;
    end
  endtask

  task automatic send_all(input logic [7:0] v[]);
    foreach (v[i]) send(v[i]);
  endtask

  int r0;
  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_opcode", 64'(opcode), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_code", 64'(err_code), 64'd0);
    rst_n = 1;
    gap(1);
    send_all('{8'hA5, 8'h03, 8'h02, 8'h11, 8'h22, 8'h32}); gap(1);
    chk("good_rdy", 64'(packet_ready), 64'd1);
    chk("good_op", 64'(opcode), 64'h03);
    chk("good_len", 64'(payload_len), 64'd2);
    chk("good_pay", payload, 64'h2211);
    send_all('{8'hA5, 8'h07, 8'h00, 8'h07}); gap(1);
    chk("zl_rdy", 64'(packet_ready), 64'd1);
    chk("zl_op", 64'(opcode), 64'h07);
    chk("zl_len", 64'(payload_len), 64'd0);
    chk("zl_pay", payload, 64'd0);
    send_all('{8'hFF, 8'h00}); gap(2);
    chk("junk_busy", 64'(busy), 64'd0);
    chk("junk_cnt", 64'(rdy_cnt), 64'd2);
    send_all('{8'hA5, 8'h01, 8'h00, 8'h00}); gap(1);
    chk("csum_err", 64'(err), 64'd1);
    chk("csum_code", 64'(err_code), 64'd1);
    chk("csum_keep_op", 64'(opcode), 64'h07);
    send_all('{8'hA5, 8'h05, 8'h09}); gap(1);
    chk("len_err", 64'(err), 64'd1);
    chk("len_code", 64'(err_code), 64'd2);
    chk("len_busy", 64'(busy), 64'd0);
    send_all('{8'hA5, 8'h02, 8'h00, 8'h02}); gap(1);
    chk("after_len_rdy", 64'(packet_ready), 64'd1);
    chk("after_len_op", 64'(opcode), 64'h02);
    send_all('{8'hA5, 8'h02, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h02}); gap(1);
    chk("max_len", 64'(payload_len), 64'd8);
    chk("max_pay", payload, 64'h0807060504030201);
    send_all('{8'hA5, 8'h04}); gap(15);
    @(posedge CLK); #1;
    chk("tmo_early", 64'(err), 64'd0);
    chk("tmo_busy", 64'(busy), 64'd1);
    gap(1);
    @(posedge CLK); #1;
    chk("tmo_err", 64'(err), 64'd1);
    chk("tmo_code", 64'(err_code), 64'd3);
    chk("tmo_idle", 64'(busy), 64'd0);
    send_all('{8'hA5, 8'h04}); gap(15);
    send_all('{8'h01, 8'h55, 8'h50}); gap(1);
    chk("tmo_sup_rdy", 64'(packet_ready), 64'd1);
    chk("tmo_sup_pay", payload, 64'h55);
    r0 = rdy_cnt;
    send_all('{8'hA5, 8'h06, 8'h01, 8'hAA, 8'hAD, 8'hA5, 8'h02, 8'h01, 8'hA5, 8'hA6}); gap(1);
    chk("b2b_cnt", 64'(rdy_cnt - r0), 64'd2);
    chk("b2b_pay", payload, 64'hA5);
    send_all('{8'hA5, 8'h03, 8'h04, 8'h11, 8'h22});
    @(posedge CLK); #2;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 0; rx_valid = 0;
    #1;
    chk("arst_op", 64'(opcode), 64'd0);
    chk("arst_pay", payload, 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    @(negedge CLK); rst_n = 1;
    gap(1);
    send_all('{8'hA5, 8'h04, 8'h01, 8'h7E, 8'h7B}); gap(1);
    chk("post_rst_rdy", 64'(packet_ready), 64'd1);
    chk("post_rst_op", 64'(opcode), 64'h04);
    chk("post_rst_pay", payload, 64'h7E);
    gap(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
